popcount_cfu_li2: RTL and testbench

POPCOUNT_CFU_LI2 -- requirements
Module: popcount_cfu_li2

---
 rtl/cfu_pkg.sv | 35 +++
 rtl/Popcount32.sv | 21 ++
 rtl/popcount_cfu_li2.sv | 131 +++++++++++++
 tb/tb_popcount_cfu_li2.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cfu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfu_pkg
// Purpose  : Shared definitions for the popcount CFU: function-id codes, the
//            S1 request record and a count zero-extension helper.
// Revision : 1.0 - initial release
// ============================================================================
package cfu_pkg;

    // Record field widths; these track the default CFU parameter values.
    localparam int CFU_FUNC_W = 5;
    localparam int CFU_ID_W   = 4;
    localparam int CFU_DATA_W = 32;

    // Function-id codes.
    localparam logic [CFU_FUNC_W-1:0] FUNC_POPCOUNT     = 5'd0;
    localparam logic [CFU_FUNC_W-1:0] FUNC_POPCOUNT_AND = 5'd1;
    localparam logic [CFU_FUNC_W-1:0] FUNC_ACCUM        = 5'd2;
    localparam logic [CFU_FUNC_W-1:0] FUNC_ACCUM_CLR    = 5'd3;

    // Request as captured in the first pipeline stage.
    typedef struct packed {
        logic [CFU_ID_W-1:0]   id;
        logic [CFU_FUNC_W-1:0] func;
        logic [CFU_DATA_W-1:0] data0;
        logic [CFU_DATA_W-1:0] data1;
    } s1_req_t;

    // Widen a 0..32 bit count to a full data word.
    function automatic logic [CFU_DATA_W-1:0] zext_count(input logic [5:0] cnt);
        return {{(CFU_DATA_W-6){1'b0}}, cnt};
    endfunction

endpackage
`default_nettype wire

// File: rtl/Popcount32.sv
`default_nettype none
// ============================================================================
// Module   : Popcount32
// Purpose  : Purely combinational count of set bits in a 32-bit word.
// Revision : 1.0 - initial release
// ============================================================================
module Popcount32 (
    input  logic [31:0] data,
    output logic [5:0]  count
);

    // Sum the individual bits; synthesis folds this into an adder tree.
    always_comb begin
        count = 6'd0;
        for (int i = 0; i < 32; i++) begin
            count = count + {5'd0, data[i]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/popcount_cfu_li2.sv
`default_nettype none
// ============================================================================
// Module   : popcount_cfu_li2
// Purpose  : Two-stage valid/ready custom function unit returning popcount
//            results. S1 holds the accepted request, S2 holds the response.
//            Optional accumulator (funcs 2/3) is built only when the macro
//            POPCOUNT_CFU_ACCUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module popcount_cfu_li2
    import cfu_pkg::*;
#(
    parameter int CFU_FUNC_ID_W   = 5,
    parameter int CFU_REQ_DATA_W  = 32,
    parameter int CFU_RESP_DATA_W = 32,
    parameter int CFU_REQ_ID_W    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [CFU_REQ_ID_W-1:0]    req_id,
    input  logic [CFU_FUNC_ID_W-1:0]   req_func_id,
    input  logic [CFU_REQ_DATA_W-1:0]  req_data0,
    input  logic [CFU_REQ_DATA_W-1:0]  req_data1,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [CFU_REQ_ID_W-1:0]    resp_id,
    output logic [CFU_RESP_DATA_W-1:0] resp_data,
    output logic                       resp_err
);

    logic                       r_s1_valid;
    s1_req_t                    r_s1;
    logic                       r_s2_valid;
    logic [CFU_REQ_ID_W-1:0]    r_resp_id;
    logic [CFU_RESP_DATA_W-1:0] r_resp_data;
    logic                       r_resp_err;

    logic                       w_s1_adv;
    logic [31:0]                w_pop_operand;
    logic [5:0]                 w_pop_count;
    logic [31:0]                w_result;
    logic                       w_err;

    // S1 moves on when S2 is free or is being drained in the same cycle;
    // the ready path is therefore combinational from resp_ready.
    assign w_s1_adv  = r_s1_valid && (!r_s2_valid || resp_ready);
    assign req_ready = !r_s1_valid || w_s1_adv;

    // The counter only ever sees registered operands.
    assign w_pop_operand = (r_s1.func == FUNC_POPCOUNT_AND) ? (r_s1.data0 & r_s1.data1)
                                                            : r_s1.data0;

    Popcount32 u_popcount32 (
        .data  (w_pop_operand),
        .count (w_pop_count)
    );

`ifdef POPCOUNT_CFU_ACCUM_EN
    logic [31:0] r_acc;
    logic [31:0] w_acc_sum;

    assign w_acc_sum = r_acc + zext_count(w_pop_count);

    // Accumulator commits only as its request leaves S1, keeping program order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= 32'd0;
        end else if (w_s1_adv) begin
            if (r_s1.func == FUNC_ACCUM) begin
                r_acc <= w_acc_sum;
            end else if (r_s1.func == FUNC_ACCUM_CLR) begin
                r_acc <= 32'd0;
            end
        end
    end
`endif

    // Decode the S1 function into the response word and error flag.
    always_comb begin
        w_result = 32'd0;
        w_err    = 1'b0;
        case (r_s1.func)
            FUNC_POPCOUNT,
            FUNC_POPCOUNT_AND: w_result = zext_count(w_pop_count);
`ifdef POPCOUNT_CFU_ACCUM_EN
            FUNC_ACCUM:        w_result = w_acc_sum;
            FUNC_ACCUM_CLR:    w_result = r_acc;
`endif
            default:           w_err    = 1'b1;
        endcase
    end

    // S1: capture a request whenever the stage can take one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (req_ready) begin
            r_s1_valid <= req_valid;
            if (req_valid) begin
                r_s1 <= '{id: req_id, func: req_func_id, data0: req_data0, data1: req_data1};
            end
        end
    end

    // S2: load from S1 on advance, empty on drain, otherwise hold outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_resp_id   <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid  <= 1'b1;
            r_resp_id   <= r_s1.id;
            r_resp_data <= CFU_RESP_DATA_W'(w_result);
            r_resp_err  <= w_err;
        end else if (resp_ready) begin
            r_s2_valid  <= 1'b0;
        end
    end

    assign resp_valid = r_s2_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_popcount_cfu_li2.sv
`default_nettype none
// ============================================================================
// Module   : tb_popcount_cfu_li2
// Purpose  : Scoreboard bench for popcount_cfu_li2: a driver pushes expected
//            responses from a reference model, a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_popcount_cfu_li2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_id;
    logic [4:0]  req_func_id;
    logic [31:0] req_data0;
    logic [31:0] req_data1;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_id;
    logic [31:0] resp_data;
    logic        resp_err;

    popcount_cfu_li2 dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_id      (req_id),
        .req_func_id (req_func_id),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
        .resp_err    (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic        err;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] m_acc  = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: counts ones directly from the functional rules.
    task automatic model(input logic [3:0] id, input logic [4:0] f,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input bit lat, output exp_t e);
        e.id = id; e.data = 32'd0; e.err = 1'b0; e.acc_cyc = cyc; e.chk_lat = lat;
        case (f)
            5'd0: e.data = $countones(d0);
            5'd1: e.data = $countones(d0 & d1);
`ifdef POPCOUNT_CFU_ACCUM_EN
            5'd2: begin m_acc = m_acc + $countones(d0); e.data = m_acc; end
            5'd3: begin e.data = m_acc; m_acc = 32'd0; end
`endif
            default: e.err = 1'b1;
        endcase
    endtask

    // One cycle of driving; called just after a rising edge.
    task automatic drive(input bit v, input logic [3:0] id, input logic [4:0] f,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input bit rr, input bit lat, output bit accepted);
        exp_t e;
        req_valid = v; req_id = id; req_func_id = f;
        req_data0 = d0; req_data1 = d1; resp_ready = rr;
        @(negedge clk);
        accepted = req_valid && req_ready;
        if (accepted) begin
            model(id, f, d0, d1, lat, e);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, a);
    endtask

    // Send one request with resp_ready high, retrying until accepted.
    task automatic send(input logic [3:0] id, input logic [4:0] f,
                        input logic [31:0] d0, input logic [31:0] d1, input bit lat);
        bit a;
        a = 1'b0;
        for (int i = 0; i < 20 && !a; i++) drive(1'b1, id, f, d0, d1, 1'b1, lat, a);
        if (!a) begin errors++; $display("FAIL send_timeout: id %0d not accepted", id); end
    endtask

    // Monitor: compare whatever is presented against the queue head.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_resp: id %0d data 0x%08h with empty scoreboard", resp_id, resp_data);
            end else begin
                chk("resp_id",   {28'd0, resp_id}, {28'd0, q[0].id});
                chk("resp_data", resp_data, q[0].data);
                chk("resp_err",  {31'd0, resp_err}, {31'd0, q[0].err});
                if (q[0].chk_lat) chk("latency", cyc - q[0].acc_cyc, 32'd2);
                if (resp_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        bit a;
        int n_acc;
        logic [3:0]  pid;
        rst = 1'b1; req_valid = 1'b0; req_id = '0; req_func_id = '0;
        req_data0 = '0; req_data1 = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data",  resp_data, 32'd0);
        chk("rst_resp_id",    {28'd0, resp_id}, 32'd0);
        chk("rst_resp_err",   {31'd0, resp_err}, 32'd0);
        chk("rst_req_ready",  {31'd0, req_ready}, 32'd1);

        // Isolated requests with latency check, then AND, then bad func.
        send(4'd3, 5'd0, 32'hF0F0F0F0, 32'd0, 1'b1);
        idle(4);
        send(4'd4, 5'd1, 32'hFFFF0000, 32'h0FF00FF0, 1'b1);
        idle(4);
        send(4'd9, 5'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        idle(4);

        // Stall: back-to-back requests with the response side blocked.
        n_acc = 0; pid = 4'd5;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, pid, 5'd0, {28'd0, pid}, 32'd0, 1'b0, 1'b0, a);
            if (a) begin n_acc++; pid = pid + 4'd1; end
        end
        chk("stall_accepts",   n_acc, 32'd2);
        chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
        send(pid, 5'd0, {28'd0, pid}, 32'd0, 1'b0);
        idle(6);

`ifdef POPCOUNT_CFU_ACCUM_EN
        send(4'd1, 5'd3, 32'd0, 32'd0, 1'b0);
        send(4'd2, 5'd2, 32'hFFFFFFFF, 32'd0, 1'b0);
        send(4'd3, 5'd2, 32'hFFFFFFFF, 32'd0, 1'b0);
        send(4'd4, 5'd3, 32'd0, 32'd0, 1'b0);
        send(4'd5, 5'd2, 32'h00000001, 32'd0, 1'b0);
        idle(5);
`endif

        // Randomised traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), 5'($urandom_range(0, 7)),
                  $urandom, $urandom, $urandom_range(0, 9) < 7, 1'b0, a);
        end
        idle(6);

        // Reset with both stages full: nothing may come out afterwards.
        drive(1'b1, 4'd10, 5'd0, 32'h1, 32'd0, 1'b0, 1'b0, a);
        drive(1'b1, 4'd11, 5'd0, 32'h3, 32'd0, 1'b0, 1'b0, a);
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        q.delete();
        m_acc = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("postrst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        idle(6);
        send(4'd12, 5'd0, 32'h0000FFFF, 32'd0, 1'b1);

        // Bounded drain.
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
